// File: rtl/seg7_mux_driver.sv
// Time-multiplexed N-digit 7-segment driver.
// Scans one digit per REFRESH_DIV clocks, decodes BCD to segments, and
// swaps in newly loaded data only at frame boundaries so a frame never
// mixes old and new digits. Optional leading-zero blanking.
module seg7_mux_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    load,
    input  logic                    lzb_en,
    output logic                    pending,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF =
        (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [PRE_W-1:0]        prescaler_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic [4*NUM_DIGITS-1:0] shadow_reg;
    logic [4*NUM_DIGITS-1:0] display_reg;
    logic                    pending_reg;
    logic                    new_frame_reg;
    logic [6:0]              seg_reg;
    logic [NUM_DIGITS-1:0]   an_reg;
    logic                    frame_start_reg;

    logic                    tick;
    logic                    frame_end;
    logic [3:0]              digit_nib [NUM_DIGITS];
    logic [NUM_DIGITS:0]     zero_from;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   an_onehot;
    logic [3:0]              cur_nib;
    logic                    cur_blank;
    logic [6:0]              lit;
    logic [6:0]              seg_next;
    logic [NUM_DIGITS-1:0]   an_next;

    assign tick      = (prescaler_reg == PRE_LAST);
    assign frame_end = tick && (idx_reg == IDX_LAST);

    // zero_from[k] is set when digit k and every more-significant digit are 0;
    // digit 0 is never blanked so an all-zero word still shows a single "0".
    assign zero_from[NUM_DIGITS] = 1'b1;
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_nib[gi] = display_reg[4*gi +: 4];
            assign zero_from[gi] = (digit_nib[gi] == 4'd0) && zero_from[gi+1];
            assign an_onehot[gi] = (idx_reg == IDX_W'(gi));
            if (gi == 0) begin : g_lsd
                assign blank[gi] = 1'b0;
            end else begin : g_upper
                assign blank[gi] = lzb_en && zero_from[gi];
            end
        end
    endgenerate

    assign cur_nib   = digit_nib[idx_reg];
    assign cur_blank = blank[idx_reg];

    // Prescaler: counts 0..REFRESH_DIV-1, tick on the last count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler_reg <= '0;
        end else if (tick) begin
            prescaler_reg <= '0;
        end else begin
            prescaler_reg <= prescaler_reg + 1'b1;
        end
    end

    // Digit index: advances on each tick, wrapping after the last digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_reg <= '0;
        end else if (tick) begin
            if (idx_reg == IDX_LAST) begin
                idx_reg <= '0;
            end else begin
                idx_reg <= idx_reg + 1'b1;
            end
        end
    end

    // Load/pending handshake: the shadow is copied to the display only at a
    // frame end; a load on that same edge refills the shadow and keeps pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_reg  <= '0;
            display_reg <= '0;
            pending_reg <= 1'b0;
        end else begin
            if (frame_end && pending_reg) begin
                display_reg <= shadow_reg;
            end
            if (load) begin
                shadow_reg  <= bcd_in;
                pending_reg <= 1'b1;
            end else if (frame_end && pending_reg) begin
                pending_reg <= 1'b0;
            end
        end
    end

    // Decode the current digit to lit-high segments, then apply polarity.
    always_comb begin
        lit = 7'b0000000;
        case (cur_nib)
            4'd0: lit = 7'b1111110;
            4'd1: lit = 7'b0110000;
            4'd2: lit = 7'b1101101;
            4'd3: lit = 7'b1111001;
            4'd4: lit = 7'b0110011;
            4'd5: lit = 7'b1011011;
            4'd6: lit = 7'b1011111;
            4'd7: lit = 7'b1110000;
            4'd8: lit = 7'b1111111;
            4'd9: lit = 7'b1111011;
            default: lit = 7'b0000000;
        endcase
        if (cur_blank) begin
            lit = 7'b0000000;
        end
        seg_next = (SEG_ACTIVE_LOW != 0) ? ~lit : lit;
        an_next  = (AN_ACTIVE_LOW != 0) ? ~an_onehot : an_onehot;
    end

    // Registered outputs; new_frame_reg delays frame_end (and reset release)
    // by one cycle so frame_start lines up with an first showing digit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_reg         <= SEG_OFF;
            an_reg          <= AN_OFF;
            frame_start_reg <= 1'b0;
            new_frame_reg   <= 1'b1;
        end else begin
            seg_reg         <= seg_next;
            an_reg          <= an_next;
            frame_start_reg <= new_frame_reg;
            new_frame_reg   <= frame_end;
        end
    end

    assign seg         = seg_reg;
    assign an          = an_reg;
    assign frame_start = frame_start_reg;
    assign pending     = pending_reg;

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Scoreboard bench for seg7_mux_driver: a frame-level model predicts the
// outputs after every clock edge; a monitor pops and compares. Two DUTs share
// the stimulus, one with each output polarity.
module tb_seg7_mux_driver;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int FRAME = N * DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bcd_in = 16'h0;
    logic        load = 1'b0;
    logic        lzb_en = 1'b0;

    logic        pending_a, frame_start_a;
    logic [6:0]  seg_a;
    logic [3:0]  an_a;
    logic        pending_b, frame_start_b;
    logic [6:0]  seg_b;
    logic [3:0]  an_b;

    always #5 clk = ~clk;

    seg7_mux_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV),
                      .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)) u_dut (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load), .lzb_en(lzb_en),
        .pending(pending_a), .seg(seg_a), .an(an_a), .frame_start(frame_start_a));

    seg7_mux_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV),
                      .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)) u_inv (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load), .lzb_en(lzb_en),
        .pending(pending_b), .seg(seg_b), .an(an_b), .frame_start(frame_start_b));

    typedef struct packed {
        logic [6:0] lit;
        logic [3:0] onehot;
        logic       fs;
        logic       pend;
    } exp_t;

    exp_t sb_q[$];
    int errors = 0;
    int checks = 0;

    // Reference model state: cycle count since reset release plus the
    // shadow/display/pending words.
    int          t;
    logic [15:0] m_shadow, m_display;
    logic        m_pending;
    logic        lzb_r;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] lit_of(input int v);
        case (v)
            0: return 7'b1111110;
            1: return 7'b0110000;
            2: return 7'b1101101;
            3: return 7'b1111001;
            4: return 7'b0110011;
            5: return 7'b1011011;
            6: return 7'b1011111;
            7: return 7'b1110000;
            8: return 7'b1111111;
            9: return 7'b1111011;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [6:0] model_lit(input logic [15:0] word, input int d, input logic lzb);
        logic [15:0] upper;
        upper = word >> (4 * d);
        if (lzb && d > 0 && upper == 16'h0) return 7'b0000000;
        return lit_of(int'(upper[3:0]));
    endfunction

    task automatic model_reset();
        t = 0;
        m_shadow = 16'h0;
        m_display = 16'h0;
        m_pending = 1'b0;
    endtask

    // Drive inputs for the coming edge, predict outputs after it, then wait.
    task automatic step(input logic ld, input logic [15:0] val, input logic lzb);
        exp_t e;
        int   d;
        logic fe;
        load = ld;
        bcd_in = val;
        lzb_en = lzb;
        d  = (t / DIV) % N;
        fe = ((t % FRAME) == FRAME - 1);
        e.lit    = model_lit(m_display, d, lzb);
        e.onehot = 4'(1 << d);
        e.fs     = ((t % FRAME) == 0);
        if (fe && m_pending) begin
            m_display = m_shadow;
            if (!ld) m_pending = 1'b0;
        end
        if (ld) begin
            m_shadow = val;
            m_pending = 1'b1;
        end
        e.pend = m_pending;
        sb_q.push_back(e);
        t++;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic lzb);
        for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), lzb);
    endtask

    task automatic idle_until(input int phase, input logic lzb);
        while ((t % FRAME) != phase) step(1'b0, 16'($urandom), lzb);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_seg_a"}, 32'(seg_a), 32'h7F);
        chk({tag, "_an_a"}, 32'(an_a), 32'hF);
        chk({tag, "_seg_b"}, 32'(seg_b), 32'h00);
        chk({tag, "_an_b"}, 32'(an_b), 32'h0);
        chk({tag, "_fs"}, 32'({frame_start_a, frame_start_b}), 32'h0);
        chk({tag, "_pending"}, 32'({pending_a, pending_b}), 32'h0);
    endtask

    // Mid-scan asynchronous reset; outputs must go idle before any clock edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        load = 1'b0;
        #1 check_reset_outputs("async_rst");
        sb_q.delete();
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("held_rst");
        rst = 1'b0;
        model_reset();
    endtask

    // Monitor: every edge outside reset presents an output word to compare.
    initial begin
        exp_t       e;
        logic [6:0] es_a;
        logic [3:0] ea_a;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                es_a = ~e.lit;
                ea_a = ~e.onehot;
                chk("seg_a", 32'(seg_a), 32'(es_a));
                chk("an_a", 32'(an_a), 32'(ea_a));
                chk("seg_b", 32'(seg_b), 32'(e.lit));
                chk("an_b", 32'(an_b), 32'(e.onehot));
                chk("frame_start_a", 32'(frame_start_a), 32'(e.fs));
                chk("frame_start_b", 32'(frame_start_b), 32'(e.fs));
                chk("pending_a", 32'(pending_a), 32'(e.pend));
                chk("pending_b", 32'(pending_b), 32'(e.pend));
            end
        end
    end

    // Stimulus.
    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        idle(6, 1'b0);
        // Scan order with 1234.
        step(1'b1, 16'h1234, 1'b0);
        idle(40, 1'b0);
        // Frame-synchronous update mid-frame.
        idle_until(6, 1'b0);
        step(1'b1, 16'h5678, 1'b0);
        idle(36, 1'b0);
        // Two loads in one frame: last write wins.
        idle_until(2, 1'b0);
        step(1'b1, 16'h1111, 1'b0);
        idle(3, 1'b0);
        step(1'b1, 16'h2222, 1'b0);
        idle(40, 1'b0);
        // Load coincident with frame_end while another load is pending.
        idle_until(3, 1'b0);
        step(1'b1, 16'h4444, 1'b0);
        idle_until(FRAME - 1, 1'b0);
        step(1'b1, 16'h3333, 1'b0);
        idle(40, 1'b0);
        // Leading-zero blanking.
        step(1'b1, 16'h0070, 1'b1);
        idle(40, 1'b1);
        step(1'b1, 16'h0000, 1'b1);
        idle(40, 1'b1);
        idle(20, 1'b0);
        // Invalid nibble.
        step(1'b1, 16'h00C0, 1'b0);
        idle(36, 1'b0);
        idle(20, 1'b1);
        // Reset mid-frame with a load pending.
        idle_until(9, 1'b0);
        step(1'b1, 16'h9999, 1'b0);
        idle(2, 1'b0);
        do_reset();
        idle(20, 1'b0);

        // Randomized traffic.
        lzb_r = 1'b0;
        for (int i = 0; i < 800; i++) begin
            logic [15:0] v;
            for (int k = 0; k < 4; k++) v[4*k +: 4] = 4'($urandom_range(0, 11));
            if ($urandom_range(0, 3) == 0) v = v & 16'h00FF;
            if ($urandom_range(0, 19) == 0) lzb_r = ~lzb_r;
            if ($urandom_range(0, 7) == 0) step(1'b1, v, lzb_r);
            else step(1'b0, v, lzb_r);
        end
        load = 1'b0;

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
